axis_egress_fifo: RTL and testbench

- Parametrised successor to the pass-through AXI-Stream egress stage.
- Adds a DEPTH-entry first-word-fall-through buffer, byte-enable (tkeep) carriage, a synchronous flush, an occupancy output and optional frame/stall statistics.
- Sits at the parser output, decoupling downstream backpressure from the parse pipeline.
- All outputs are registered; there is no combinational path from m_tready to s_tready.

---
 rtl/axis_egress_fifo.sv | 123 ++++++++++++
 tb/tb_axis_egress_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_egress_fifo.sv
// axis_egress_fifo: DEPTH-entry first-word-fall-through AXI-Stream egress buffer.
// Carries tdata/tkeep/tlast/tuser verbatim, supports a synchronous flush and
// reports occupancy. Every output is registered, so m_tready never reaches
// s_tready combinationally.
// Optional statistics (frames_out, stall_cycles) are compiled in when the
// macro AXIS_EGRESS_FIFO_STATS_EN is defined.
module axis_egress_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 4,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    s_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_tkeep,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic                     s_tlast,
    input  logic [USER_WIDTH-1:0]    s_tuser,
    output logic [DATA_WIDTH-1:0]    m_tdata,
    output logic [KEEP_WIDTH-1:0]    m_tkeep,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tlast,
    output logic [USER_WIDTH-1:0]    m_tuser,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef AXIS_EGRESS_FIFO_STATS_EN
    ,
    output logic [31:0]              frames_out,
    output logic [31:0]              stall_cycles
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic [USER_WIDTH-1:0] user;
    } beat_t;

    beat_t         mem [DEPTH];
    beat_t         s_beat;
    beat_t         m_beat;
    beat_t         head_nxt;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] wr_nxt, rd_nxt, occ_nxt;
    logic          push, pop;
    logic          full_nxt, empty_nxt;

    assign s_beat = '{data: s_tdata, keep: s_tkeep, last: s_tlast, user: s_tuser};

    assign m_tdata = m_beat.data;
    assign m_tkeep = m_beat.keep;
    assign m_tlast = m_beat.last;
    assign m_tuser = m_beat.user;

    // Next-state pointers and the entry that will be at the head after this edge.
    always_comb begin
        push      = s_tvalid && s_tready;
        pop       = m_tvalid && m_tready;
        wr_nxt    = wr_ptr + PW'(push);
        rd_nxt    = rd_ptr + PW'(pop);
        occ_nxt   = wr_nxt - rd_nxt;
        full_nxt  = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
        empty_nxt = (wr_nxt == rd_nxt);
        // The new head is the incoming word only when it lands in the slot
        // being advanced to, i.e. the buffer was (or becomes) otherwise empty.
        if (push && (rd_nxt == wr_ptr))
            head_nxt = s_beat;
        else
            head_nxt = mem[rd_nxt[AW-1:0]];
    end

    // Storage write; a push coinciding with reset or flush is discarded.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush)
            mem[wr_ptr[AW-1:0]] <= s_beat;
    end

    // Pointers, flags and the registered head. Flush mirrors reset, so
    // s_tready drops for one cycle after either and returns on the next edge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            m_tvalid  <= 1'b0;
            s_tready  <= 1'b0;
            m_beat    <= '0;
        end else begin
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            occupancy <= occ_nxt;
            m_tvalid  <= !empty_nxt;
            s_tready  <= !full_nxt;
            // Hold the last word when draining to empty; m_tvalid masks it.
            if (!empty_nxt)
                m_beat <= head_nxt;
        end
    end

`ifdef AXIS_EGRESS_FIFO_STATS_EN
    // Saturating frame and stall counters; cleared by reset only, not flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_out   <= '0;
            stall_cycles <= '0;
        end else begin
            if (m_tvalid && m_tready && m_tlast && (frames_out != 32'hFFFF_FFFF))
                frames_out <= frames_out + 32'd1;
            if (s_tvalid && !s_tready && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_egress_fifo.sv
// tb_axis_egress_fifo: directed scenarios plus a randomized phase, all checked
// every cycle against a queue-based transaction model of the buffer.
module tb_axis_egress_fifo;

    localparam int DW = 64;
    localparam int UW = 1;
    localparam int DEPTH = 4;
    localparam int KW = DW / 8;

    logic            clk = 1'b0;
    logic            rst, flush;
    logic [DW-1:0]   s_tdata;
    logic [KW-1:0]   s_tkeep;
    logic            s_tvalid, s_tready, s_tlast;
    logic [UW-1:0]   s_tuser;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tvalid, m_tready, m_tlast;
    logic [UW-1:0]   m_tuser;
    logic [$clog2(DEPTH):0] occupancy;
`ifdef AXIS_EGRESS_FIFO_STATS_EN
    logic [31:0]     frames_out, stall_cycles;
`endif

    axis_egress_fifo #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .occupancy(occupancy)
`ifdef AXIS_EGRESS_FIFO_STATS_EN
        , .frames_out(frames_out), .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic [UW-1:0] u;
    } ent_t;

    ent_t        q[$];
    logic        exp_srdy;
    longint      exp_frames, exp_stall;
    int          n_tests, n_fail;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [DW-1:0] d, input logic [KW-1:0] k,
                       input logic l, input logic [UW-1:0] u);
        s_tvalid = v;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
    endtask

    // One clock: evaluate the model's transfer decisions on current inputs,
    // advance the clock, update the model and compare all visible state.
    task automatic cycle();
        logic acc, pop, stall_inc, frame_inc;
        ent_t e;
        acc       = s_tvalid && exp_srdy;
        pop       = (q.size() > 0) && m_tready;
        stall_inc = s_tvalid && !exp_srdy;
        frame_inc = pop && q[0].l;
        e.d = s_tdata; e.k = s_tkeep; e.l = s_tlast; e.u = s_tuser;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_frames = 0;
            exp_stall  = 0;
        end else begin
            if (frame_inc && exp_frames < 64'hFFFF_FFFF) exp_frames++;
            if (stall_inc && exp_stall  < 64'hFFFF_FFFF) exp_stall++;
        end
        if (rst || flush) begin
            q.delete();
            exp_srdy = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
            exp_srdy = (q.size() < DEPTH);
        end
        chk("s_tready", s_tready, exp_srdy);
        chk("m_tvalid", m_tvalid, q.size() > 0);
        chk("occupancy", occupancy, q.size());
        if (q.size() > 0) begin
            chk("m_tdata", m_tdata, q[0].d);
            chk("m_tkeep", m_tkeep, q[0].k);
            chk("m_tlast", m_tlast, q[0].l);
            chk("m_tuser", m_tuser, q[0].u);
        end
`ifdef AXIS_EGRESS_FIFO_STATS_EN
        chk("frames_out", frames_out, exp_frames);
        chk("stall_cycles", stall_cycles, exp_stall);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drv(1'b0, '0, '0, 1'b0, '0);
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        exp_srdy = 1'b0; exp_frames = 0; exp_stall = 0;
        rst = 1'b1; flush = 1'b0; m_tready = 1'b0;
        drv(1'b0, '0, '0, 1'b0, '0);

        // Reset then idle
        do_reset();
        chk("rst_m_tdata", m_tdata, 64'h0);
        chk("rst_m_tkeep", m_tkeep, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tuser", m_tuser, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_s_tready", s_tready, 1);

        // Backpressure fill, then a refused word
        m_tready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drv(1'b1, DW'(i), 8'hFF, 1'b0, '0);
            cycle();
        end
        drv(1'b1, 64'h5, 8'h0F, 1'b1, '0);
        repeat (3) begin
            cycle();
            chk("fill_m_tdata", m_tdata, 64'h1);
        end
        chk("fill_occ", occupancy, 4);
        chk("fill_s_tready", s_tready, 0);

        // Drain after fill; 0x5 enters once room opens
        m_tready = 1'b1;
        cycle();
        chk("drain_first", m_tdata, 64'h2);
        cycle();
        drv(1'b0, '0, '0, 1'b0, '0);
        repeat (3) cycle();
        chk("drain_last_data", m_tdata, 64'h5);
        chk("drain_last_keep", m_tkeep, 8'h0F);
        chk("drain_last_tlast", m_tlast, 1);
        repeat (2) cycle();

        // Streaming: continuous push with m_tready high
        for (int i = 0; i < 16; i++) begin
            drv(1'b1, 64'h100 + DW'(i), 8'hFF, (i % 4) == 3, UW'(i & 1));
            cycle();
            chk("stream_occ_le1", occupancy <= 1, 1);
        end
        drv(1'b0, '0, '0, 1'b0, '0);
        repeat (2) cycle();

        // Flush coinciding with a push
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 64'hA0 + DW'(i), 8'hFF, 1'b0, '0);
            cycle();
        end
        chk("pre_flush_occ", occupancy, 3);
        drv(1'b1, 64'hDEAD_BEEF_CAFE_BABE, 8'hFF, 1'b1, '0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drv(1'b0, '0, '0, 1'b0, '0);
        chk("flush_occ", occupancy, 0);
        chk("flush_m_tvalid", m_tvalid, 0);
        m_tready = 1'b1;
        repeat (3) cycle();
        chk("flush_word_gone", m_tvalid, 0);

        // Statistics scenario: 3 frames of 2 words, 5 refused cycles
        do_reset();
        m_tready = 1'b0;
        drv(1'b1, 64'h11, 8'hFF, 1'b0, '0); cycle();
        drv(1'b1, 64'h12, 8'hFF, 1'b1, '0); cycle();
        drv(1'b1, 64'h21, 8'hFF, 1'b0, '0); cycle();
        drv(1'b1, 64'h22, 8'hFF, 1'b1, '0); cycle();
        drv(1'b1, 64'h31, 8'hFF, 1'b0, '0);
        repeat (4) cycle();
        m_tready = 1'b1;
        cycle();
        cycle();
        drv(1'b1, 64'h32, 8'hFF, 1'b1, '0); cycle();
        drv(1'b0, '0, '0, 1'b0, '0);
        repeat (6) cycle();
`ifdef AXIS_EGRESS_FIFO_STATS_EN
        chk("stats_frames", frames_out, 3);
        chk("stats_stall", stall_cycles, 5);
        flush = 1'b1; cycle(); flush = 1'b0; cycle();
        chk("stats_frames_after_flush", frames_out, 3);
        chk("stats_stall_after_flush", stall_cycles, 5);
`endif

        // Randomized traffic with occasional flush
        for (int n = 0; n < 600; n++) begin
            drv($urandom_range(0, 3) != 0, {$urandom, $urandom}, KW'($urandom),
                $urandom_range(0, 3) == 0, UW'($urandom));
            m_tready = $urandom_range(0, 2) != 0;
            flush    = $urandom_range(0, 59) == 0;
            cycle();
        end
        flush = 1'b0;
        drv(1'b0, '0, '0, 1'b0, '0);
        m_tready = 1'b1;
        repeat (6) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
